fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the instruction fetch path: owns the program counter, drives the instruction-memory address, and captures the returned instruction word together with its PC. It accepts control-flow redirects from execute and buffers fetched words in a small FIFO so decode can back-pressure without losing instructions. Sits between the instruction memory, which has a combinational read, and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, fetch-buffer entries (power of two, ≥2)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- fetch_en  in  1  1 = fetch permitted; 0 = stop issuing new fetches
- imem_addr  out  32  current PC to instruction memory
- imem_rdata  in  32  instruction word for imem_addr, same cycle
- redirect_valid  in  1  single-cycle pulse: branch/jump taken
- redirect_pc  in  32  target PC; bits [1:0] ignored, treated as 0
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  32  PC of head instruction

## Operation
- States: IDLE, RUN. Reset → IDLE. IDLE → RUN when fetch_en=1. RUN → IDLE when fetch_en=0. Redirect does not change state.
- imem_addr = pc register at all times, in both states.
- Push in RUN when fetch_en=1 and redirect_valid=0, and either count<DEPTH or a pop happens in the same cycle. A push writes {pc, imem_rdata} to the tail and sets pc ← pc+4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Pop occurs when out_valid && out_ready. out_instr/out_pc come from the head entry. They are 0 when empty.
- Redirect (any state): pc ← {redirect_pc[31:2], 2'b00}; the buffer is flushed (count ← 0); no push that cycle.
  - A pop in the same cycle counts as consumed. The flush removes the rest.
- IDLE: no pushes. Existing entries stay in the buffer and drain normally through out_ready.
- Full with out_ready=0: pc holds; imem_addr stays stable; no entry is overwritten.
- Empty: out_valid=0. Decode asserting out_ready has no effect.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, count=0, state=IDLE.
- Reset asserted mid-operation overrides redirect, push and pop in that cycle.
- Fetch latency:
  - The word at address A is pushed at the end of the cycle in which imem_addr=A.
  - out_valid rises the following cycle.
  - First instruction after reset release with fetch_en=1: enters RUN at cycle 0, first push at cycle 1, out_valid=1 at cycle 2.
- Throughput: 1 instruction/cycle sustained when out_ready=1, including when the buffer is full (simultaneous push+pop).
- Redirect at cycle t:
  - out_valid=0 at t+1.
  - imem_addr=target at t+1, pushed that cycle.
  - out_valid=1 with out_pc=target at t+2.
- Outputs are registered/FIFO-head only; no combinational path from out_ready or redirect_valid to out_valid/out_instr/out_pc.
- imem_addr depends only on the pc register.

## Structure
- Package fetch_pkg holds:
  - fetch_entry_t: packed {pc[31:0], instr[31:0]}
  - PC_STEP = 4
  - the state enum {IDLE, RUN}
  - DEFAULT_RESET_PC
- Sub-module fetch_fifo (DEPTH-entry synchronous FIFO of fetch_entry_t) with push, pop, flush, full, empty and count.
  - flush has priority over push.
- fetch_ctrl holds only the state register, the pc register and the push/redirect logic.

## Test plan
- Reset release, fetch_en=1, out_ready=1, memory returns word = address ^ 32'hA5A5_0000 → out_pc sequence 0,4,8,… from cycle 2, one per cycle, each out_instr matching.
- out_ready=0 for 5 cycles from the start → after 2 pushes the buffer is full, imem_addr holds at 8, and out_pc=0 at head. Releasing out_ready → 0,4,8 delivered back-to-back with no gap or duplicate.
- Redirect to 32'h0000_1003 at cycle 6 while 2 entries are buffered → out_valid=0 at cycle 7, imem_addr=32'h0000_1000 at cycle 7, out_pc=32'h0000_1000 at cycle 8, then 32'h0000_1004.
- RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- fetch_en dropped while 2 entries are buffered → state IDLE, no new pushes, both entries still delivered, imem_addr frozen. Raising fetch_en resumes from the frozen PC.
- reset asserted in the same cycle as redirect_valid and a pop → next cycle pc=RESET_PC, out_valid=0, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Entry layout, PC step, FSM states and default reset PC.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// Flush wins over push; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_N = (AW + 1)'(DEPTH);
  localparam logic [AW:0] C_ONE = 1;
  localparam logic [AW-1:0] P_ONE = 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full  = (count == FULL_N);
  assign empty = (count == '0);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, IDLE/RUN FSM, redirect handling.
// Fetched words are queued in fetch_fifo toward decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t       state;
  state_t       state_nx;
  logic [31:0]  pc;
  logic [31:0]  pc_nx;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [CW-1:0] count;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fetch_en)  state_nx = RUN;
      RUN:     if (!fetch_en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid = (count != '0);
  assign pop = out_ready && !empty;

  // A full buffer still accepts a word when the head leaves this cycle.
  always_comb begin
    push = (state == RUN) && fetch_en
        && !redirect_valid && (!full || pop);
    pc_nx = pc;
    unique case (1'b1)
      redirect_valid: pc_nx = redirect_pc & ~32'h3;
      push:           pc_nx = pc + PC_STEP;
      default:        ;
    endcase
  end

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign imem_addr = pc;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC scoreboard queue.
// A second instance exercises PC wraparound at the top of memory.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] out_instr, out_pc;
  logic        out_valid;
  logic [31:0] imem_addr2, imem_rdata2;
  logic [31:0] out_instr2, out_pc2;
  logic        out_valid2;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr ^ KEY;
  assign imem_rdata2 = imem_addr2 ^ KEY;

  fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
  );

  fetch_ctrl #(
    .RESET_PC(32'hFFFF_FFF8),
    .DEPTH(2)
  ) dut2 (
    .clk(clk),
    .reset(reset),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid2),
    .out_ready(out_ready),
    .out_instr(out_instr2),
    .out_pc(out_pc2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic sb_done(input string tag);
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_drain: %0d undelivered, expected 0",
             tag, sb.size());
    end
  endtask

  // Compare any handshake in the current cycle, then advance.
  task automatic cyc();
    logic [31:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra: observed pc %h expected none",
               out_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, e ^ KEY);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

    // streaming, plus wraparound on dut2
    reset = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    chk("c0_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("c1_state", 32'(dut.state), 32'(RUN));
    chk("c1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("stream_valid", 32'(out_valid), 32'd1);
      if (i < 4) begin
        chk("wrap_pc", out_pc2,
            32'hFFFF_FFF8 + 32'(i * 4));
        chk("wrap_instr", out_instr2,
            (32'hFFFF_FFF8 + 32'(i * 4)) ^ KEY);
      end
    end
    cyc();
    out_ready = 1'b0;
    sb_done("stream");

    // back-pressure until full, then release
    do_reset();
    fetch_en = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    sb.push_back(32'hC);
    sb.push_back(32'h10);
    repeat (3) cyc();
    chk("bp_addr3", imem_addr, 32'h8);
    cyc();
    chk("bp_addr4", imem_addr, 32'h8);
    chk("bp_head", out_pc, 32'h0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_run_valid", 32'(out_valid), 32'd1);
      cyc();
    end
    out_ready = 1'b0;
    sb_done("bp");

    // redirect with two entries buffered
    do_reset();
    fetch_en = 1'b1;
    repeat (6) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    sb.push_back(32'h1000);
    sb.push_back(32'h1004);
    cyc();
    redirect_valid = 1'b0;
    chk("rd_valid7", 32'(out_valid), 32'd0);
    chk("rd_addr7", imem_addr, 32'h1000);
    out_ready = 1'b1;
    cyc();
    chk("rd_valid8", 32'(out_valid), 32'd1);
    chk("rd_pc8", out_pc, 32'h1000);
    cyc();
    chk("rd_pc9", out_pc, 32'h1004);
    cyc();
    out_ready = 1'b0;
    sb_done("rd");

    // fetch_en dropped with a full buffer
    do_reset();
    fetch_en = 1'b1;
    repeat (3) cyc();
    fetch_en = 1'b0;
    cyc();
    chk("en_state", 32'(dut.state), 32'(IDLE));
    chk("en_addr4", imem_addr, 32'h8);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("en_empty", 32'(out_valid), 32'd0);
    chk("en_addr6", imem_addr, 32'h8);
    fetch_en = 1'b1;
    sb.push_back(32'h8);
    cyc();
    chk("en_resume_addr", imem_addr, 32'h8);
    cyc();
    chk("en_valid8", 32'(out_valid), 32'd1);
    chk("en_pc8", out_pc, 32'h8);
    cyc();
    out_ready = 1'b0;
    sb_done("en");

    // reset colliding with redirect and pop
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b1;
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    repeat (3) cyc();
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    cyc();
    reset = 1'b0;
    redirect_valid = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    chk("rr_addr", imem_addr, 32'h0);
    chk("rr_valid", 32'(out_valid), 32'd0);
    chk("rr_pc", out_pc, 32'h0);
    chk("rr_state", 32'(dut.state), 32'(IDLE));
    sb_done("rr");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
